// File: rtl/micro_pkg.sv
// Shared definitions for the control-unit micro-sequencer and the control ROM.
//   ns_sel_e : next-state select encodings carried in the control-ROM word
//   fc_e     : fault cause codes reported on fault_code
//   DEF_*    : default microstate addresses shared with the control ROM
package micro_pkg;

  typedef enum logic [2:0] {
    NS_ENCODE   = 3'd0,
    NS_INC      = 3'd1,
    NS_JUMP     = 3'd2,
    NS_CBR      = 3'd3,
    NS_WAIT_MFC = 3'd4,
    NS_CALL     = 3'd5,
    NS_RET      = 3'd6,
    NS_FETCH    = 3'd7
  } ns_sel_e;

  typedef enum logic [1:0] {
    FC_NONE     = 2'd0,
    FC_ILLEGAL  = 2'd1,
    FC_TIMEOUT  = 2'd2,
    FC_STACK    = 2'd3
  } fc_e;

  localparam logic [7:0] DEF_RESET_STATE = 8'd0;
  localparam logic [7:0] DEF_FETCH_STATE = 8'd1;
  localparam logic [7:0] DEF_FAULT_STATE = 8'd255;

endpackage

// File: rtl/micro_stack.sv
// Two-entry, 8-bit LIFO holding microsequencer return addresses.
//   clk, reset : clock and synchronous active-high reset
//   push, pop  : push din / discard top (never both in one cycle)
//   din        : value to push
//   top        : most recently pushed entry (undefined meaning when empty)
//   full/empty : sp==2 / sp==0
module micro_stack (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic [7:0] top,
  output logic       full,
  output logic       empty
);

  logic [7:0] entry [2];
  logic [1:0] sp;

  assign full  = (sp == 2'd2);
  assign empty = (sp == 2'd0);
  assign top   = full ? entry[1] : entry[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      sp <= '0;
      for (int unsigned i = 0; i < 2; i++) entry[i] <= '0;
    end else if (push && !full) begin
      entry[sp[0]] <= din;
      sp           <= sp + 2'd1;
    end else if (pop && !empty) begin
      sp <= sp - 2'd1;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microstate register and next-state logic for the control unit.
//   clk, reset  : clock and synchronous active-high reset
//   enc_state   : starting microstate from the instruction encoder
//   ns_sel      : next-state select from the current control-ROM word
//   cr_addr     : target address from the current control-ROM word
//   cond_in,inv : condition result and its invert bit (CBR only)
//   mfc         : memory function complete (WAIT_MFC only)
//   stall       : hold state, stack and wait counter this cycle
//   state       : current microstate (control-ROM address), registered
//   fault       : sticky fault flag; state parks at FAULT_STATE until reset
//   fault_code  : cause of the fault (fc_e)
module micro_sequencer
  import micro_pkg::*;
#(
  parameter logic [7:0]  RESET_STATE = DEF_RESET_STATE,
  parameter logic [7:0]  FETCH_STATE = DEF_FETCH_STATE,
  parameter logic [7:0]  FAULT_STATE = DEF_FAULT_STATE,
  parameter int unsigned WAIT_LIMIT  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] enc_state,
  input  logic [2:0] ns_sel,
  input  logic [7:0] cr_addr,
  input  logic       cond_in,
  input  logic       inv,
  input  logic       mfc,
  input  logic       stall,
  output logic [7:0] state,
  output logic       fault,
  output logic [1:0] fault_code
);

  localparam int unsigned WCW = (WAIT_LIMIT > 2) ? $clog2(WAIT_LIMIT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(WAIT_LIMIT - 1);

  ns_sel_e        ns;
  logic [7:0]     state_q, state_d;
  logic           fault_q, fault_d;
  fc_e            code_q, code_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [7:0]     inc;
  logic           taken;
  logic           push, pop;
  logic [7:0]     stk_top;
  logic           stk_full, stk_empty;

  assign ns    = ns_sel_e'(ns_sel);
  assign inc   = state_q + 8'd1;
  assign taken = cond_in ^ inv;

  micro_stack u_stack (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    code_d  = code_q;
    wcnt_d  = wcnt_q;
    push    = 1'b0;
    pop     = 1'b0;
    // A latched fault freezes everything; stall freezes state, stack and counter.
    if (!fault_q && !stall) begin
      if (ns != NS_WAIT_MFC) wcnt_d = '0;
      case (ns)
        NS_ENCODE: begin
          if (enc_state == 8'd0) begin
            state_d = FAULT_STATE;
            fault_d = 1'b1;
            code_d  = FC_ILLEGAL;
          end else begin
            state_d = enc_state;
          end
        end
        NS_INC:  state_d = inc;
        NS_JUMP: state_d = cr_addr;
        NS_CBR:  state_d = taken ? cr_addr : inc;
        NS_WAIT_MFC: begin
          if (mfc) begin
            state_d = inc;
            wcnt_d  = '0;
          end else if (wcnt_q == WAIT_LAST) begin
            state_d = FAULT_STATE;
            fault_d = 1'b1;
            code_d  = FC_TIMEOUT;
          end else begin
            wcnt_d = wcnt_q + WCW'(1);
          end
        end
        NS_CALL: begin
          if (stk_full) begin
            state_d = FAULT_STATE;
            fault_d = 1'b1;
            code_d  = FC_STACK;
          end else begin
            push    = 1'b1;
            state_d = cr_addr;
          end
        end
        NS_RET: begin
          if (stk_empty) begin
            state_d = FAULT_STATE;
            fault_d = 1'b1;
            code_d  = FC_STACK;
          end else begin
            pop     = 1'b1;
            state_d = stk_top;
          end
        end
        NS_FETCH: state_d = FETCH_STATE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RESET_STATE;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      wcnt_q  <= wcnt_d;
    end
  end

  assign state      = state_q;
  assign fault      = fault_q;
  assign fault_code = code_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Randomized + directed bench for micro_sequencer with a behavioural model.
module tb_micro_sequencer;

  localparam int WL = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] enc_state = '0;
  logic [2:0] ns_sel = '0;
  logic [7:0] cr_addr = '0;
  logic       cond_in = 1'b0;
  logic       inv = 1'b0;
  logic       mfc = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] state;
  logic       fault;
  logic [1:0] fault_code;

  int n_vec = 0;
  int n_bad = 0;

  // Behavioural model: microstate, sticky fault, return-address queue, wait count.
  int m_state = 0;
  int m_fault = 0;
  int m_code  = 0;
  int m_stk[$];
  int m_wait  = 0;

  micro_sequencer #(.WAIT_LIMIT(WL)) dut (
    .clk        (clk),
    .reset      (reset),
    .enc_state  (enc_state),
    .ns_sel     (ns_sel),
    .cr_addr    (cr_addr),
    .cond_in    (cond_in),
    .inv        (inv),
    .mfc        (mfc),
    .stall      (stall),
    .state      (state),
    .fault      (fault),
    .fault_code (fault_code)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic trap(input int code);
    m_state = 255;
    m_fault = 1;
    m_code  = code;
  endtask

  task automatic model_update();
    int nxt;
    nxt = (m_state + 1) % 256;
    if (reset) begin
      m_state = 0; m_fault = 0; m_code = 0; m_wait = 0;
      m_stk.delete();
    end else if (m_fault == 0 && !stall) begin
      if (ns_sel != 3'd4) m_wait = 0;
      case (ns_sel)
        3'd0: if (enc_state == 0) trap(1); else m_state = enc_state;
        3'd1: m_state = nxt;
        3'd2: m_state = cr_addr;
        3'd3: m_state = (cond_in != inv) ? int'(cr_addr) : nxt;
        3'd4: begin
          if (mfc) begin m_state = nxt; m_wait = 0; end
          else if (m_wait == WL - 1) trap(2);
          else m_wait++;
        end
        3'd5: begin
          if (m_stk.size() == 2) trap(3);
          else begin m_stk.push_back(nxt); m_state = cr_addr; end
        end
        3'd6: begin
          if (m_stk.size() == 0) trap(3);
          else m_state = m_stk.pop_back();
        end
        default: m_state = 1;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic r, input logic [2:0] ns,
                      input logic [7:0] cr, input logic [7:0] enc, input logic c,
                      input logic iv, input logic m, input logic st);
    reset = r; ns_sel = ns; cr_addr = cr; enc_state = enc;
    cond_in = c; inv = iv; mfc = m; stall = st;
    model_update();
    @(posedge clk);
    #1;
    check_val({tag, ".state"}, state, 8'(m_state));
    check_val({tag, ".fault"}, {7'd0, fault}, 8'(m_fault));
    check_val({tag, ".code"}, {6'd0, fault_code}, 8'(m_code));
  endtask

  // Shorthand for an ordinary non-reset, non-stall cycle.
  task automatic go(input string tag, input logic [2:0] ns, input logic [7:0] cr);
    step(tag, 1'b0, ns, cr, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // 1: reset mid-sequence, fetch, encode
    step("rst0", 1'b1, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    go("j", 3'd2, 8'd77);
    step("rst_mid", 1'b1, 3'd1, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("rst_mid.abs", state, 8'd0);
    go("fetch", 3'd7, 8'd0);
    check_val("fetch.abs", state, 8'd1);
    step("enc33", 1'b0, 3'd0, 8'd0, 8'd33, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("enc33.abs", state, 8'd33);

    // 2: CBR taken / inverted, INC wrap
    go("j10", 3'd2, 8'd10);
    step("cbr_t", 1'b0, 3'd3, 8'd40, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    check_val("cbr_t.abs", state, 8'd40);
    go("j10b", 3'd2, 8'd10);
    step("cbr_nt", 1'b0, 3'd3, 8'd40, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
    check_val("cbr_nt.abs", state, 8'd11);
    go("j255", 3'd2, 8'd255);
    go("wrap", 3'd1, 8'd0);
    check_val("wrap.abs", state, 8'd0);

    // 3: short memory wait
    go("j30", 3'd2, 8'd30);
    for (int i = 0; i < 3; i++) go("wait", 3'd4, 8'd0);
    step("mfc", 1'b0, 3'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    check_val("mfc.abs", state, 8'd31);

    // Stall with mfc=1 mid-wait must neither advance nor count
    for (int i = 0; i < 10; i++) go("w2", 3'd4, 8'd0);
    for (int i = 0; i < 4; i++)
      step("wstall", 1'b0, 3'd4, 8'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1);

    // 4: timeout, then sticky through activity and stall
    for (int i = 0; i < WL; i++) go("tmo", 3'd4, 8'd0);
    check_val("tmo.abs_state", state, 8'd255);
    check_val("tmo.abs_code", {6'd0, fault_code}, 8'd2);
    go("sticky_j", 3'd2, 8'd5);
    step("sticky_s", 1'b0, 3'd7, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    go("sticky_r", 3'd6, 8'd0);

    // 5: call/return stack
    step("rst5", 1'b1, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    go("j20", 3'd2, 8'd20);
    go("call50", 3'd5, 8'd50);
    go("call60", 3'd5, 8'd60);
    go("ret51", 3'd6, 8'd0);
    check_val("ret51.abs", state, 8'd51);
    go("ret21", 3'd6, 8'd0);
    check_val("ret21.abs", state, 8'd21);
    go("ret_uf", 3'd6, 8'd0);
    check_val("ret_uf.abs", {6'd0, fault_code}, 8'd3);
    step("rst5b", 1'b1, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    go("c1", 3'd5, 8'd70);
    go("c2", 3'd5, 8'd80);
    go("c_of", 3'd5, 8'd90);
    check_val("c_of.abs", {6'd0, fault_code}, 8'd3);

    // 6: illegal encode; stall during JUMP preserves state and stack depth
    step("rst6", 1'b1, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("enc0", 1'b0, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check_val("enc0.abs", {6'd0, fault_code}, 8'd1);
    step("rst6b", 1'b1, 3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    go("c100", 3'd5, 8'd100);
    step("stallj", 1'b0, 3'd2, 8'd9, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check_val("stallj.abs", state, 8'd100);
    go("ret1", 3'd6, 8'd0);
    check_val("ret1.abs", state, 8'd1);

    // Randomized phase
    for (int i = 0; i < 2500; i++) begin
      logic r, st;
      r  = ($urandom_range(0, 99) == 0) || (m_fault != 0 && $urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) begin
        for (int k = 0; k < 18; k++)
          step("rnd_wait", 1'b0, 3'd4, 8'($urandom), 8'($urandom),
               1'($urandom), 1'($urandom), ($urandom_range(0, 29) == 0),
               ($urandom_range(0, 5) == 0));
      end else begin
        step("rnd", r, 3'($urandom_range(0, 7)), 8'($urandom),
             ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255)),
             1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0), st);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
